// File: rtl/l2_cpu_req_arbiter.sv
// l2_cpu_req_arbiter: shares the L2 CPU request and read-response channels between
// requester 0 (core) and requester 1 (accelerator/debug port). One owner per transaction,
// grant held across READ_ATOM/WRITE_ATOM pairs.
// Build option: define L2_ARB_RR_EN for round-robin arbitration (default: fixed priority, req 0).
module l2_cpu_req_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned LINE_W = 128
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  // requester 0
  input  logic              i_req_0_valid,
  input  logic [1:0]        i_req_0_cpu_msg,
  input  logic [2:0]        i_req_0_hsize,
  input  logic [1:0]        i_req_0_hprot,
  input  logic [ADDR_W-1:0] i_req_0_addr,
  input  logic [WORD_W-1:0] i_req_0_word,
  output logic              o_req_0_ready,
  output logic              o_rsp_0_valid,
  output logic [LINE_W-1:0] o_rsp_0_line,
  input  logic              i_rsp_0_ready,
  // requester 1
  input  logic              i_req_1_valid,
  input  logic [1:0]        i_req_1_cpu_msg,
  input  logic [2:0]        i_req_1_hsize,
  input  logic [1:0]        i_req_1_hprot,
  input  logic [ADDR_W-1:0] i_req_1_addr,
  input  logic [WORD_W-1:0] i_req_1_word,
  output logic              o_req_1_ready,
  output logic              o_rsp_1_valid,
  output logic [LINE_W-1:0] o_rsp_1_line,
  input  logic              i_rsp_1_ready,
  // L2 request channel
  output logic              o_l2_cpu_req_valid,
  output logic [1:0]        o_l2_cpu_req_data_cpu_msg,
  output logic [2:0]        o_l2_cpu_req_data_hsize,
  output logic [1:0]        o_l2_cpu_req_data_hprot,
  output logic [ADDR_W-1:0] o_l2_cpu_req_data_addr,
  output logic [WORD_W-1:0] o_l2_cpu_req_data_word,
  input  logic              i_l2_cpu_req_ready,
  // L2 read-response channel
  input  logic              i_l2_rd_rsp_valid,
  input  logic [LINE_W-1:0] i_l2_rd_rsp_data_line,
  output logic              o_l2_rd_rsp_ready,
  // debug
  output logic              o_owner,
  output logic              o_locked
);

  localparam logic [1:0] MsgRead      = 2'b00;
  localparam logic [1:0] MsgReadAtom  = 2'b01;
  localparam logic [1:0] MsgWrite     = 2'b10;
  localparam logic [1:0] MsgWriteAtom = 2'b11;

  typedef enum logic [1:0] {StIdle, StIssue, StWaitRsp, StLocked} state_e;

  state_e r_state, w_state_nxt;
  logic   r_owner, w_owner_nxt;
  logic   r_locked, w_locked_nxt;
  logic   w_winner;

  logic              w_own_valid;
  logic [1:0]        w_own_msg;
  logic [2:0]        w_own_hsize;
  logic [1:0]        w_own_hprot;
  logic [ADDR_W-1:0] w_own_addr;
  logic [WORD_W-1:0] w_own_word;
  logic              w_own_rsp_ready;
  logic              w_req_hs;
  logic              w_rsp_hs;

`ifdef L2_ARB_RR_EN
  logic r_last, w_last_nxt;

  // Round-robin: on contention the requester that did not win last time is granted.
  always_comb begin
    if (i_req_0_valid && i_req_1_valid) w_winner = ~r_last;
    else                                w_winner = i_req_1_valid;
  end
`else
  // Fixed priority: requester 0 wins whenever it is valid.
  always_comb begin
    w_winner = ~i_req_0_valid;
  end
`endif

  // Select the current owner's request fields and response-ready.
  always_comb begin
    if (r_owner) begin
      w_own_valid     = i_req_1_valid;
      w_own_msg       = i_req_1_cpu_msg;
      w_own_hsize     = i_req_1_hsize;
      w_own_hprot     = i_req_1_hprot;
      w_own_addr      = i_req_1_addr;
      w_own_word      = i_req_1_word;
      w_own_rsp_ready = i_rsp_1_ready;
    end else begin
      w_own_valid     = i_req_0_valid;
      w_own_msg       = i_req_0_cpu_msg;
      w_own_hsize     = i_req_0_hsize;
      w_own_hprot     = i_req_0_hprot;
      w_own_addr      = i_req_0_addr;
      w_own_word      = i_req_0_word;
      w_own_rsp_ready = i_rsp_0_ready;
    end
  end

  // Channel outputs: request forwarded only in ISSUE, response routed only in WAIT_RSP.
  always_comb begin
    o_l2_cpu_req_valid        = (r_state == StIssue) && w_own_valid;
    o_l2_cpu_req_data_cpu_msg = '0;
    o_l2_cpu_req_data_hsize   = '0;
    o_l2_cpu_req_data_hprot   = '0;
    o_l2_cpu_req_data_addr    = '0;
    o_l2_cpu_req_data_word    = '0;
    if (o_l2_cpu_req_valid) begin
      o_l2_cpu_req_data_cpu_msg = w_own_msg;
      o_l2_cpu_req_data_hsize   = w_own_hsize;
      o_l2_cpu_req_data_hprot   = w_own_hprot;
      o_l2_cpu_req_data_addr    = w_own_addr;
      o_l2_cpu_req_data_word    = w_own_word;
    end
    o_req_0_ready     = (r_state == StIssue) && !r_owner && i_l2_cpu_req_ready;
    o_req_1_ready     = (r_state == StIssue) &&  r_owner && i_l2_cpu_req_ready;
    o_rsp_0_valid     = (r_state == StWaitRsp) && !r_owner && i_l2_rd_rsp_valid;
    o_rsp_1_valid     = (r_state == StWaitRsp) &&  r_owner && i_l2_rd_rsp_valid;
    o_rsp_0_line      = o_rsp_0_valid ? i_l2_rd_rsp_data_line : '0;
    o_rsp_1_line      = o_rsp_1_valid ? i_l2_rd_rsp_data_line : '0;
    // Stray responses outside WAIT_RSP stall here rather than being dropped.
    o_l2_rd_rsp_ready = (r_state == StWaitRsp) && w_own_rsp_ready;
    o_owner           = r_owner;
    o_locked          = r_locked;
    w_req_hs          = o_l2_cpu_req_valid && i_l2_cpu_req_ready;
    w_rsp_hs          = o_l2_rd_rsp_ready && i_l2_rd_rsp_valid;
  end

  // Next-state: grant in IDLE, track atomic lock on accepted requests.
  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_locked_nxt = r_locked;
`ifdef L2_ARB_RR_EN
    w_last_nxt   = r_last;
`endif
    unique case (r_state)
      StIdle: begin
        if (i_req_0_valid || i_req_1_valid) begin
          w_owner_nxt = w_winner;
`ifdef L2_ARB_RR_EN
          w_last_nxt  = w_winner;
`endif
          w_state_nxt = StIssue;
        end
      end
      StIssue: begin
        if (w_req_hs) begin
          case (w_own_msg)
            MsgRead: w_state_nxt = StWaitRsp;
            MsgReadAtom: begin
              w_locked_nxt = 1'b1;
              w_state_nxt  = StWaitRsp;
            end
            MsgWrite: w_state_nxt = r_locked ? StLocked : StIdle;
            MsgWriteAtom: begin
              w_locked_nxt = 1'b0;
              w_state_nxt  = StIdle;
            end
            default: w_state_nxt = StIdle;
          endcase
        end
      end
      StWaitRsp: begin
        if (w_rsp_hs) w_state_nxt = r_locked ? StLocked : StIdle;
      end
      StLocked: begin
        // Only the owner may continue; the other requester waits for the unlock.
        if (w_own_valid) w_state_nxt = StIssue;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_owner  <= 1'b0;
      r_locked <= 1'b0;
`ifdef L2_ARB_RR_EN
      r_last   <= 1'b1;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_locked <= w_locked_nxt;
`ifdef L2_ARB_RR_EN
      r_last   <= w_last_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_l2_cpu_req_arbiter.sv
// Scoreboard bench for l2_cpu_req_arbiter: expected L2 requests and requester responses are
// queued at stimulus time and popped by a monitor on each observed handshake.
module tb_l2_cpu_req_arbiter;

  localparam logic [1:0] MsgRead      = 2'b00;
  localparam logic [1:0] MsgReadAtom  = 2'b01;
  localparam logic [1:0] MsgWrite     = 2'b10;
  localparam logic [1:0] MsgWriteAtom = 2'b11;

  typedef struct packed {
    logic        src;
    logic [1:0]  msg;
    logic [2:0]  hsize;
    logic [1:0]  hprot;
    logic [31:0] addr;
    logic [31:0] word;
  } req_t;

  typedef struct packed {
    logic         dst;
    logic [127:0] line;
  } rsp_t;

  logic clk, rst_n;
  logic req_0_valid, req_1_valid, req_0_ready, req_1_ready;
  logic [1:0] req_0_msg, req_1_msg, req_0_hprot, req_1_hprot;
  logic [2:0] req_0_hsize, req_1_hsize;
  logic [31:0] req_0_addr, req_1_addr, req_0_word, req_1_word;
  logic rsp_0_valid, rsp_1_valid, rsp_0_ready, rsp_1_ready;
  logic [127:0] rsp_0_line, rsp_1_line;
  logic l2_req_valid, l2_req_ready;
  logic [1:0] l2_msg, l2_hprot;
  logic [2:0] l2_hsize;
  logic [31:0] l2_addr, l2_word;
  logic l2_rsp_valid, l2_rsp_ready;
  logic [127:0] l2_rsp_line;
  logic owner, locked;

  int checks = 0;
  int errors = 0;
  req_t exp_req_q[$];
  rsp_t exp_rsp_q[$];

  l2_cpu_req_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_0_valid(req_0_valid), .i_req_0_cpu_msg(req_0_msg), .i_req_0_hsize(req_0_hsize),
    .i_req_0_hprot(req_0_hprot), .i_req_0_addr(req_0_addr), .i_req_0_word(req_0_word),
    .o_req_0_ready(req_0_ready), .o_rsp_0_valid(rsp_0_valid), .o_rsp_0_line(rsp_0_line),
    .i_rsp_0_ready(rsp_0_ready),
    .i_req_1_valid(req_1_valid), .i_req_1_cpu_msg(req_1_msg), .i_req_1_hsize(req_1_hsize),
    .i_req_1_hprot(req_1_hprot), .i_req_1_addr(req_1_addr), .i_req_1_word(req_1_word),
    .o_req_1_ready(req_1_ready), .o_rsp_1_valid(rsp_1_valid), .o_rsp_1_line(rsp_1_line),
    .i_rsp_1_ready(rsp_1_ready),
    .o_l2_cpu_req_valid(l2_req_valid), .o_l2_cpu_req_data_cpu_msg(l2_msg),
    .o_l2_cpu_req_data_hsize(l2_hsize), .o_l2_cpu_req_data_hprot(l2_hprot),
    .o_l2_cpu_req_data_addr(l2_addr), .o_l2_cpu_req_data_word(l2_word),
    .i_l2_cpu_req_ready(l2_req_ready),
    .i_l2_rd_rsp_valid(l2_rsp_valid), .i_l2_rd_rsp_data_line(l2_rsp_line),
    .o_l2_rd_rsp_ready(l2_rsp_ready),
    .o_owner(owner), .o_locked(locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic req_t mk(input logic src, input logic [1:0] msg, input logic [31:0] addr,
                              input logic [31:0] word);
    req_t r;
    r.src = src; r.msg = msg; r.hsize = 3'd2; r.hprot = 2'd3; r.addr = addr; r.word = word;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request on its requester port and hold it until accepted.
  task automatic do_req(input req_t r);
    int n = 0;
    if (r.src) begin
      req_1_valid = 1'b1; req_1_msg = r.msg; req_1_hsize = r.hsize; req_1_hprot = r.hprot;
      req_1_addr = r.addr; req_1_word = r.word;
    end else begin
      req_0_valid = 1'b1; req_0_msg = r.msg; req_0_hsize = r.hsize; req_0_hprot = r.hprot;
      req_0_addr = r.addr; req_0_word = r.word;
    end
    while (n < 64) begin
      @(negedge clk);
      if (r.src ? req_1_ready : req_0_ready) break;
      n++;
    end
    chk("req_accept_timeout", 128'(n >= 64), 128'(0));
    @(posedge clk);
    #1;
    if (r.src) req_1_valid = 1'b0;
    else       req_0_valid = 1'b0;
  endtask

  // Present one L2 read response, holding the destination's ready low for 'stall' cycles.
  task automatic do_rsp(input logic dst, input logic [127:0] line, input int stall);
    int n = 0;
    rsp_t e;
    e.dst = dst; e.line = line;
    exp_rsp_q.push_back(e);
    l2_rsp_valid = 1'b1;
    l2_rsp_line  = line;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("rsp_stall_l2_ready", 128'(l2_rsp_ready), 128'(0));
      chk("rsp_stall_valid", 128'(dst ? rsp_1_valid : rsp_0_valid), 128'(1));
      @(posedge clk);
      #1;
    end
    if (dst) rsp_1_ready = 1'b1;
    else     rsp_0_ready = 1'b1;
    while (n < 64) begin
      @(negedge clk);
      if (l2_rsp_ready) break;
      n++;
    end
    chk("rsp_accept_timeout", 128'(n >= 64), 128'(0));
    chk("rsp_other_valid", 128'(dst ? rsp_0_valid : rsp_1_valid), 128'(0));
    @(posedge clk);
    #1;
    l2_rsp_valid = 1'b0;
    rsp_0_ready  = 1'b0;
    rsp_1_ready  = 1'b0;
  endtask

  task automatic apply_reset();
    req_0_valid = 0; req_0_msg = 0; req_0_hsize = 0; req_0_hprot = 0; req_0_addr = 0;
    req_0_word = 0;
    req_1_valid = 0; req_1_msg = 0; req_1_hsize = 0; req_1_hprot = 0; req_1_addr = 0;
    req_1_word = 0;
    rsp_0_ready = 0; rsp_1_ready = 0; l2_rsp_valid = 0; l2_rsp_line = 0; l2_req_ready = 1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
  endtask

  // Monitor: pop and compare on every request and response handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (l2_req_valid && l2_req_ready) begin
        if (exp_req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL req_unexpected got addr %0h owner %0b", l2_addr, owner);
        end else begin
          req_t e;
          e = exp_req_q.pop_front();
          chk("l2_req", 128'({owner, l2_msg, l2_hsize, l2_hprot, l2_addr, l2_word}), 128'(e));
        end
      end
      if ((rsp_0_valid && rsp_0_ready) || (rsp_1_valid && rsp_1_ready)) begin
        if (exp_rsp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected got line %0h", rsp_0_valid ? rsp_0_line : rsp_1_line);
        end else begin
          rsp_t e;
          e = exp_rsp_q.pop_front();
          chk("rsp_line", rsp_1_valid ? {1'b1, rsp_1_line} : {1'b0, rsp_0_line}, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t r;
    // Reset state
    apply_reset();
    chk("reset_outputs", 128'({l2_req_valid, req_0_ready, req_1_ready, rsp_0_valid,
        rsp_1_valid, l2_rsp_ready, owner, locked, l2_addr}), 128'(0));

    // Single READ from requester 0
    r = mk(1'b0, MsgRead, 32'h8000_0010, 32'h0);
    exp_req_q.push_back(r);
    do_req(r);
    tick();
    tick();
    do_rsp(1'b0, {16{8'hA5}}, 0);
    @(negedge clk);
    chk("idle_after_read", 128'({l2_req_valid, l2_rsp_ready, locked}), 128'(0));

    // Contention: both requesters issue four writes each
    apply_reset();
    for (int i = 0; i < 4; i++) begin
`ifdef L2_ARB_RR_EN
      exp_req_q.push_back(mk(1'b0, MsgWrite, 32'h1000_0000 + 32'(i * 4), 32'hA000_0000 + 32'(i)));
      exp_req_q.push_back(mk(1'b1, MsgWrite, 32'h2000_0000 + 32'(i * 4), 32'hB000_0000 + 32'(i)));
`else
      exp_req_q.push_back(mk(1'b0, MsgWrite, 32'h1000_0000 + 32'(i * 4), 32'hA000_0000 + 32'(i)));
`endif
    end
`ifndef L2_ARB_RR_EN
    for (int i = 0; i < 4; i++)
      exp_req_q.push_back(mk(1'b1, MsgWrite, 32'h2000_0000 + 32'(i * 4), 32'hB000_0000 + 32'(i)));
`endif
    fork
      begin
        for (int i = 0; i < 4; i++)
          do_req(mk(1'b0, MsgWrite, 32'h1000_0000 + 32'(i * 4), 32'hA000_0000 + 32'(i)));
      end
      begin
        for (int j = 0; j < 4; j++)
          do_req(mk(1'b1, MsgWrite, 32'h2000_0000 + 32'(j * 4), 32'hB000_0000 + 32'(j)));
      end
    join

    // Atomic pair from requester 1 while requester 0 waits
    exp_req_q.push_back(mk(1'b1, MsgReadAtom, 32'h3000_0040, 32'h0));
    exp_req_q.push_back(mk(1'b1, MsgWriteAtom, 32'h3000_0040, 32'h1234_5678));
    exp_req_q.push_back(mk(1'b0, MsgRead, 32'h4000_0000, 32'h0));
    fork
      begin
        do_req(mk(1'b1, MsgReadAtom, 32'h3000_0040, 32'h0));
        chk("locked_after_read_atom", 128'(locked), 128'(1));
        do_rsp(1'b1, {4{32'hC0DE_0001}}, 0);
        chk("locked_owner_after_rsp", 128'({locked, owner}), 128'(2'b11));
        @(negedge clk);
        chk("locked_no_grant", 128'({l2_req_valid, req_0_ready}), 128'(0));
        tick();
        do_req(mk(1'b1, MsgWriteAtom, 32'h3000_0040, 32'h1234_5678));
        chk("unlocked_after_write_atom", 128'(locked), 128'(0));
      end
      begin
        tick();
        do_req(mk(1'b0, MsgRead, 32'h4000_0000, 32'h0));
        do_rsp(1'b0, {4{32'h0BAD_F00D}}, 0);
      end
    join

    // L2 back-pressure on the request channel for five cycles
    l2_req_ready = 1'b0;
    r = mk(1'b0, MsgWrite, 32'h5000_0008, 32'hDEAD_BEEF);
    exp_req_q.push_back(r);
    fork
      do_req(r);
      begin
        tick();
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("stall_fields", 128'({l2_req_valid, owner, l2_msg, l2_addr, l2_word}),
              128'({1'b1, 1'b0, MsgWrite, 32'h5000_0008, 32'hDEAD_BEEF}));
          chk("stall_ready0", 128'(req_0_ready), 128'(0));
          @(posedge clk);
          #1;
        end
        l2_req_ready = 1'b1;
      end
    join

    // Response back-pressure from requester 0 for three cycles
    r = mk(1'b0, MsgRead, 32'h6000_0020, 32'h0);
    exp_req_q.push_back(r);
    do_req(r);
    do_rsp(1'b0, {2{64'h0123_4567_89AB_CDEF}}, 3);

    // Reset while requester 1 holds a lock and waits for its response
    exp_req_q.push_back(mk(1'b1, MsgReadAtom, 32'h7000_0000, 32'h0));
    do_req(mk(1'b1, MsgReadAtom, 32'h7000_0000, 32'h0));
    l2_rsp_valid = 1'b1;
    l2_rsp_line  = {4{32'h5555_AAAA}};
    #2;
    chk("pre_reset_state", 128'({rsp_1_valid, owner, locked}), 128'(3'b111));
    rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", 128'({l2_req_valid, req_0_ready, req_1_ready, rsp_0_valid,
        rsp_1_valid, l2_rsp_ready, owner, locked, rsp_1_line}), 128'(0));
    l2_rsp_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    r = mk(1'b1, MsgRead, 32'h7000_0100, 32'h0);
    exp_req_q.push_back(r);
    fork
      do_req(r);
      begin
        @(negedge clk);
        chk("latency_t", 128'(l2_req_valid), 128'(0));
        @(negedge clk);
        chk("latency_t1", 128'({l2_req_valid, owner}), 128'(2'b11));
      end
    join
    do_rsp(1'b1, {8{16'h9E9E}}, 1);

    repeat (2) tick();
    chk("req_queue_drained", 128'(exp_req_q.size()), 128'(0));
    chk("rsp_queue_drained", 128'(exp_rsp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
